// File: rtl/bsg_cache_nb_resp_checker.sv
// bsg_cache_nb_resp_checker
//
// Checks responses on a non-blocking cache's response channel, for use in
// regression benches. Every accepted response (v_o & yumi_i while enabled) is
// compared with what its source should return:
//   - mode_i = 0: the data must be all zeros.
//   - mode_i = 1: the data must equal that source's running sequence number.
// The block also counts responses, watches for responses that sit unconsumed
// for too long, and keeps a sticky error flag and a saturating error count.
//
// Ports
//   clk_i       clock
//   reset_i     synchronous, active-high reset
//   en_i        checker enable; when low nothing is accepted or counted
//   mode_i      0 = expect zero data, 1 = expect per-source sequence
//   data_o      response data under test (named after the cache-side port)
//   src_id_o    response source id
//   v_o         response valid
//   yumi_i      response consumed
//   err_o       sticky error flag
//   err_cnt_o   saturating error count
//   resp_cnt_o  saturating count of accepted responses
//   done_o      sticky, set once expected_total_p responses have been accepted
//
// All outputs are registered and show the effect of an accept one cycle later.

module bsg_cache_nb_resp_checker #(
   parameter int word_width_p     = 32,
   parameter int src_id_width_p   = 4,
   parameter int num_src_p        = 16,
   parameter int exempt_src_id_p  = 0,
   parameter int count_width_p    = 16,
   parameter int timeout_p        = 1024,
   parameter int expected_total_p = 0,
   parameter int fatal_on_err_p   = 1
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic                      en_i,
   input  logic                      mode_i,
   input  logic [word_width_p-1:0]   data_o,
   input  logic [src_id_width_p-1:0] src_id_o,
   input  logic                      v_o,
   input  logic                      yumi_i,
   output logic                      err_o,
   output logic [count_width_p-1:0]  err_cnt_o,
   output logic [count_width_p-1:0]  resp_cnt_o,
   output logic                      done_o
);

   // Index width for the per-source table. num_src_p <= 2^src_id_width_p, so
   // the low bits of the id are enough once the id is known to be in range.
   localparam int idx_width_lp = (num_src_p > 1) ? $clog2(num_src_p) : 1;

   localparam logic [count_width_p-1:0] one_lp            = count_width_p'(1);
   localparam logic [count_width_p-1:0] timeout_last_lp   = count_width_p'(timeout_p - 1);
   localparam logic [count_width_p-1:0] expected_total_lp = count_width_p'(expected_total_p);
   localparam bit                       done_en_lp        = (expected_total_p != 0);

   logic [count_width_p-1:0] seq_r [num_src_p];
   logic [count_width_p-1:0] stall_cnt_r;
   logic [count_width_p-1:0] err_cnt_r;
   logic [count_width_p-1:0] resp_cnt_r;
   logic [count_width_p-1:0] resp_cnt_n;
   logic                     err_r;
   logic                     done_r;

   logic                     acc;
   logic                     in_range;
   logic [idx_width_lp-1:0]  src_idx;
   logic [word_width_p-1:0]  exp_data;
   logic                     range_err;
   logic                     data_err;
   logic                     overrun_err;
   logic                     stall;
   logic                     stall_err;
   logic [2:0]               n_err;
   logic [count_width_p:0]   err_sum;

   assign acc      = ~reset_i & en_i & v_o & yumi_i;
   assign in_range = (int'(src_id_o) < num_src_p);
   assign src_idx  = src_id_o[idx_width_lp-1:0];

   // Sequence values are zero-extended or truncated to the data width.
   assign exp_data = mode_i ? word_width_p'(seq_r[src_idx]) : '0;

   assign range_err   = acc & ~in_range;
   assign data_err    = acc & in_range & (int'(src_id_o) != exempt_src_id_p)
                        & (data_o != exp_data);
   assign overrun_err = acc & done_r;

   // A stall is a valid response that nobody consumes. The counter fires on
   // the timeout_p-th consecutive stalled cycle and then starts over, so a
   // persistent stall re-flags every timeout_p cycles.
   assign stall     = en_i & v_o & ~yumi_i;
   assign stall_err = ~reset_i & stall & (stall_cnt_r == timeout_last_lp);

   // Several distinct errors in one cycle each count once.
   assign n_err   = 3'(range_err) + 3'(data_err) + 3'(overrun_err) + 3'(stall_err);
   assign err_sum = {1'b0, err_cnt_r} + (count_width_p+1)'(n_err);

   assign resp_cnt_n = (acc && !(&resp_cnt_r)) ? resp_cnt_r + one_lp : resp_cnt_r;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         err_r       <= 1'b0;
         err_cnt_r   <= '0;
         resp_cnt_r  <= '0;
         done_r      <= 1'b0;
         stall_cnt_r <= '0;
         // NOTE: the sequence table is reset too, because a mid-test reset must
         // discard all history and restart every source at zero.
         for (int i = 0; i < num_src_p; i++) begin
            seq_r[i] <= '0;
         end
      end else begin
         if (acc && in_range) begin
            seq_r[src_idx] <= seq_r[src_idx] + one_lp;
         end

         resp_cnt_r <= resp_cnt_n;

         if (done_en_lp && acc && (resp_cnt_n == expected_total_lp)) begin
            done_r <= 1'b1;
         end

         if (!stall || stall_err) begin
            stall_cnt_r <= '0;
         end else begin
            stall_cnt_r <= stall_cnt_r + one_lp;
         end

         if (n_err != 3'd0) begin
            err_r     <= 1'b1;
            err_cnt_r <= err_sum[count_width_p] ? '1 : err_sum[count_width_p-1:0];

            if ((fatal_on_err_p != 0) && !err_r) begin
               $fatal(1, "bsg_cache_nb_resp_checker: src=%0d data=%h exp=%h range=%b data=%b overrun=%b stall=%b",
                      src_id_o, data_o, exp_data, range_err, data_err, overrun_err, stall_err);
            end else if (fatal_on_err_p == 0) begin
               // Non-fatal builds report through $warning so the run continues.
               $warning("bsg_cache_nb_resp_checker: src=%0d data=%h exp=%h range=%b data=%b overrun=%b stall=%b",
                        src_id_o, data_o, exp_data, range_err, data_err, overrun_err, stall_err);
            end
         end
      end
   end

   assign err_o      = err_r;
   assign err_cnt_o  = err_cnt_r;
   assign resp_cnt_o = resp_cnt_r;
   assign done_o     = done_r;

endmodule

// File: tb/tb_bsg_cache_nb_resp_checker.sv
// tb_bsg_cache_nb_resp_checker
//
// Drives two checker instances from one shared response channel:
//   dut_a: 16-bit counters, timeout 8, done disabled
//   dut_b: 4-bit counters, timeout 8, done after 4 responses
// Both use a 5-bit source id with 16 tracked sources, so ids 16..31 are out of
// range. A reference model (per-source integer arrays and plain integer
// counters) predicts every output of both instances after each clock.

module tb_bsg_cache_nb_resp_checker;

   localparam int num_src_lp = 16;
   localparam int timeout_lp = 8;
   localparam int cw_lp  [2] = '{16, 4};
   localparam int exp_lp [2] = '{0, 4};

   logic        clk_i;
   logic        reset_i;
   logic        en_i;
   logic        mode_i;
   logic [31:0] data_o;
   logic [4:0]  src_id_o;
   logic        v_o;
   logic        yumi_i;

   logic        a_err, b_err, a_done, b_done;
   logic [15:0] a_err_cnt, a_resp;
   logic [3:0]  b_err_cnt, b_resp;

   int checks = 0;
   int errors = 0;

   // Reference model state, index 0 = dut_a, 1 = dut_b.
   int m_seq  [2][num_src_lp];
   int m_resp [2];
   int m_errc [2];
   int m_run  [2];
   bit m_flag [2];
   bit m_done [2];

   bsg_cache_nb_resp_checker #(
      .word_width_p(32), .src_id_width_p(5), .num_src_p(num_src_lp),
      .exempt_src_id_p(0), .count_width_p(16), .timeout_p(timeout_lp),
      .expected_total_p(0), .fatal_on_err_p(0)
   ) dut_a (
      .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .mode_i(mode_i),
      .data_o(data_o), .src_id_o(src_id_o), .v_o(v_o), .yumi_i(yumi_i),
      .err_o(a_err), .err_cnt_o(a_err_cnt), .resp_cnt_o(a_resp), .done_o(a_done)
   );

   bsg_cache_nb_resp_checker #(
      .word_width_p(32), .src_id_width_p(5), .num_src_p(num_src_lp),
      .exempt_src_id_p(0), .count_width_p(4), .timeout_p(timeout_lp),
      .expected_total_p(4), .fatal_on_err_p(0)
   ) dut_b (
      .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .mode_i(mode_i),
      .data_o(data_o), .src_id_o(src_id_o), .v_o(v_o), .yumi_i(yumi_i),
      .err_o(b_err), .err_cnt_o(b_err_cnt), .resp_cnt_o(b_resp), .done_o(b_done)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   function automatic int cap(input int k);
      return (1 << cw_lp[k]) - 1;
   endfunction

   // Apply the checker rules to the inputs that were sampled at this edge.
   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         int  nerr = 0;
         bit  acc  = en_i & v_o & yumi_i;
         int  s    = int'(src_id_o);
         if (reset_i) begin
            for (int i = 0; i < num_src_lp; i++) m_seq[k][i] = 0;
            m_resp[k] = 0; m_errc[k] = 0; m_run[k] = 0;
            m_flag[k] = 0; m_done[k] = 0;
         end else begin
            if (acc) begin
               if (s >= num_src_lp) begin
                  nerr++;
               end else begin
                  if (s != 0 && data_o != (mode_i ? 32'(m_seq[k][s]) : 32'd0)) nerr++;
                  m_seq[k][s] = (m_seq[k][s] + 1) % (1 << cw_lp[k]);
               end
               if (m_done[k]) nerr++;
               if (m_resp[k] < cap(k)) m_resp[k]++;
               if (exp_lp[k] != 0 && m_resp[k] == exp_lp[k]) m_done[k] = 1;
            end
            if (en_i && v_o && !yumi_i) begin
               m_run[k]++;
               if (m_run[k] == timeout_lp) begin
                  nerr++;
                  m_run[k] = 0;
               end
            end else begin
               m_run[k] = 0;
            end
            if (nerr != 0) begin
               m_flag[k] = 1;
               m_errc[k] = (m_errc[k] + nerr > cap(k)) ? cap(k) : m_errc[k] + nerr;
            end
         end
      end
   endtask

   task automatic compare_all();
      check("a.err_o",      a_err,     m_flag[0]);
      check("a.err_cnt_o",  a_err_cnt, m_errc[0]);
      check("a.resp_cnt_o", a_resp,    m_resp[0]);
      check("a.done_o",     a_done,    m_done[0]);
      check("b.err_o",      b_err,     m_flag[1]);
      check("b.err_cnt_o",  b_err_cnt, m_errc[1]);
      check("b.resp_cnt_o", b_resp,    m_resp[1]);
      check("b.done_o",     b_done,    m_done[1]);
   endtask

   // Inputs change 1 time unit after the edge, so the edge sees stable values.
   task automatic cycle();
      @(posedge clk_i);
      #1;
      model_step();
      compare_all();
   endtask

   task automatic do_reset();
      reset_i = 1'b1; v_o = 1'b0; yumi_i = 1'b0;
      cycle();
      reset_i = 1'b0;
   endtask

   task automatic accept(input logic mode, input int src, input logic [31:0] data);
      en_i = 1'b1; mode_i = mode; v_o = 1'b1; yumi_i = 1'b1;
      src_id_o = 5'(src); data_o = data;
      cycle();
   endtask

   task automatic stall_n(input int n);
      en_i = 1'b1; v_o = 1'b1; yumi_i = 1'b0;
      repeat (n) cycle();
   endtask

   task automatic idle();
      v_o = 1'b0; yumi_i = 1'b0;
      cycle();
   endtask

   initial begin
      reset_i = 1'b1; en_i = 1'b0; mode_i = 1'b0; data_o = '0;
      src_id_o = '0; v_o = 1'b0; yumi_i = 1'b0;

      // Reset state.
      do_reset();
      check("reset.a.err_cnt", a_err_cnt, 0);
      check("reset.b.done",    b_done,    0);

      // Mode 0, src 3 returns zero five times; then mode 1 expects 5.
      repeat (5) accept(1'b0, 3, 32'h0);
      check("s1.a.err_o", a_err, 0);
      check("s1.a.resp",  a_resp, 5);
      accept(1'b1, 3, 32'd5);
      check("s1.a.seq3", a_err_cnt, 0);
      idle();

      // Mode 0 bad data on src 2; exempt src 0 is not data-checked.
      do_reset();
      accept(1'b0, 2, 32'hDEADBEEF);
      check("s2.a.err_o",   a_err, 1);
      check("s2.a.err_cnt", a_err_cnt, 1);
      accept(1'b0, 0, 32'h1234);
      check("s2.a.exempt", a_err_cnt, 1);
      check("s2.a.resp",   a_resp, 2);
      idle();

      // Mode 1 sequences on src 1 and src 5, interleaved.
      do_reset();
      accept(1'b1, 1, 0); accept(1'b1, 5, 0);
      accept(1'b1, 1, 1); accept(1'b1, 5, 1);
      accept(1'b1, 1, 2);
      check("s3.a.pass", a_err_cnt, 0);
      accept(1'b1, 1, 4);
      check("s3.a.skip", a_err_cnt, 1);
      accept(1'b1, 1, 4);
      check("s3.a.seq1_is_4", a_err_cnt, 1);
      idle();

      // Stall watchdog.
      do_reset();
      src_id_o = 5'd0; data_o = '0;
      stall_n(8);
      check("s4.a.stall8",  a_err_cnt, 1);
      stall_n(8);
      check("s4.a.stall16", a_err_cnt, 2);
      idle();
      do_reset();
      stall_n(4);
      accept(1'b0, 0, 32'h0);
      stall_n(7);
      check("s4.a.no_stall", a_err_cnt, 0);
      idle();

      // Done, overrun, range.
      do_reset();
      repeat (4) accept(1'b0, 0, 32'h0);
      check("s5.b.done",    b_done, 1);
      check("s5.b.err_cnt", b_err_cnt, 0);
      accept(1'b0, 0, 32'h0);
      check("s5.b.overrun", b_err_cnt, 1);
      accept(1'b0, 20, 32'h0);
      check("s5.a.range",       a_err_cnt, 1);
      check("s5.b.range+overrun", b_err_cnt, 3);
      idle();

      // Reset mid-sequence discards history.
      do_reset();
      accept(1'b1, 1, 0); accept(1'b1, 1, 1); accept(1'b1, 1, 2);
      do_reset();
      check("s6.a.resp_cleared", a_resp, 0);
      accept(1'b1, 1, 0);
      check("s6.a.restart", a_err_cnt, 0);
      idle();

      // Saturation of the 4-bit instance.
      do_reset();
      repeat (20) accept(1'b0, 2, 32'h1);
      check("s7.b.err_sat",  b_err_cnt, 15);
      check("s7.b.resp_sat", b_resp, 15);
      check("s7.a.err_cnt",  a_err_cnt, 20);
      idle();

      // Randomized traffic.
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         int s;
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else if ($urandom_range(0, 59) == 0) begin
            stall_n($urandom_range(6, 20));
         end else begin
            s        = $urandom_range(0, 19);
            en_i     = ($urandom_range(0, 9) != 0);
            mode_i   = $urandom_range(0, 1);
            v_o      = ($urandom_range(0, 9) < 7);
            yumi_i   = ($urandom_range(0, 9) < 6);
            src_id_o = 5'(s);
            if ($urandom_range(0, 9) < 7)
               data_o = (mode_i && s < num_src_lp) ? 32'(m_seq[0][s]) : 32'd0;
            else
               data_o = $urandom();
            cycle();
         end
      end
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
